// File: rtl/perf_pkg.sv
// Shared types for the backend performance counter block: FSM states and the
// five-counter record used by both the live and snapshot registers.
package perf_pkg;

  localparam int COUNTER_WIDTH_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } perf_state_e;

  // Fields are sized for the widest supported counter; narrower builds use the low bits.
  typedef struct packed {
    logic [COUNTER_WIDTH_DEFAULT-1:0] inst_retired;
    logic [COUNTER_WIDTH_DEFAULT-1:0] cycles;
    logic [COUNTER_WIDTH_DEFAULT-1:0] cycles_decoded;
    logic [COUNTER_WIDTH_DEFAULT-1:0] cycles_eligible;
    logic [COUNTER_WIDTH_DEFAULT-1:0] cycles_issued;
  } perf_counters_t;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating accumulator with enable and synchronous clear; never wraps.
// count_next exposes the value the register will take on the coming edge.
module perf_sat_counter #(
  parameter int WIDTH     = 64,
  parameter int INC_WIDTH = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [INC_WIDTH-1:0] inc,
  output logic [WIDTH-1:0]     count,
  output logic [WIDTH-1:0]     count_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, count} + {{(WIDTH+1-INC_WIDTH){1'b0}}, inc};
    count_next = count;
    if (enable) begin
      // Carry out of the top bit means the true sum exceeds the max value.
      count_next = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/backend_perf_counters.sv
// Backend performance counters: counts retired instructions and event cycles
// over a run, detects end-of-run by sustained idleness, and offers a snapshot.
module backend_perf_counters
  import perf_pkg::*;
#(
  parameter int COUNTER_WIDTH  = COUNTER_WIDTH_DEFAULT,
  parameter int RETIRE_WIDTH   = 3,
  parameter int IDLE_THRESHOLD = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     clear,
  input  logic                     busy,
  input  logic [RETIRE_WIDTH-1:0]  retire_count,
  input  logic                     ev_decoded,
  input  logic                     ev_eligible,
  input  logic                     ev_issued,
  output logic [COUNTER_WIDTH-1:0] perf_backend_instRetired,
  output logic [COUNTER_WIDTH-1:0] perf_backend_cycles,
  output logic [COUNTER_WIDTH-1:0] perf_backend_cyclesDecoded,
  output logic [COUNTER_WIDTH-1:0] perf_backend_cyclesEligible,
  output logic [COUNTER_WIDTH-1:0] perf_backend_cyclesIssued,
  output logic                     finished,
  output logic                     running,
  output logic                     snap_valid,
  input  logic                     snap_ready,
  output logic [COUNTER_WIDTH-1:0] snap_instRetired,
  output logic [COUNTER_WIDTH-1:0] snap_cycles,
  output logic [COUNTER_WIDTH-1:0] snap_cyclesDecoded,
  output logic [COUNTER_WIDTH-1:0] snap_cyclesEligible,
  output logic [COUNTER_WIDTH-1:0] snap_cyclesIssued,
  output logic [1:0]               debug_state
);

  localparam int IDLE_W = $clog2(IDLE_THRESHOLD + 1);

  perf_state_e        state;
  logic [IDLE_W-1:0]  idle_cnt;
  logic [IDLE_W-1:0]  idle_inc;
  perf_counters_t     live_next;
  perf_counters_t     snap_q;

  logic [COUNTER_WIDTH-1:0] inst_next, cyc_next, dec_next, elig_next, iss_next;

  assign debug_state = state;
  assign idle_inc    = idle_cnt + IDLE_W'(1);

  // running is high exactly in RUN and DRAIN, so it doubles as the count enable.
  perf_sat_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(RETIRE_WIDTH)) u_inst (
    .clock(clock), .reset(reset), .clear(clear), .enable(running),
    .inc(retire_count), .count(perf_backend_instRetired), .count_next(inst_next)
  );
  perf_sat_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_cyc (
    .clock(clock), .reset(reset), .clear(clear), .enable(running),
    .inc(1'b1), .count(perf_backend_cycles), .count_next(cyc_next)
  );
  perf_sat_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_dec (
    .clock(clock), .reset(reset), .clear(clear), .enable(running),
    .inc(ev_decoded), .count(perf_backend_cyclesDecoded), .count_next(dec_next)
  );
  perf_sat_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_elig (
    .clock(clock), .reset(reset), .clear(clear), .enable(running),
    .inc(ev_eligible), .count(perf_backend_cyclesEligible), .count_next(elig_next)
  );
  perf_sat_counter #(.WIDTH(COUNTER_WIDTH), .INC_WIDTH(1)) u_iss (
    .clock(clock), .reset(reset), .clear(clear), .enable(running),
    .inc(ev_issued), .count(perf_backend_cyclesIssued), .count_next(iss_next)
  );

  always_comb begin
    live_next = '0;
    live_next.inst_retired[COUNTER_WIDTH-1:0]    = inst_next;
    live_next.cycles[COUNTER_WIDTH-1:0]          = cyc_next;
    live_next.cycles_decoded[COUNTER_WIDTH-1:0]  = dec_next;
    live_next.cycles_eligible[COUNTER_WIDTH-1:0] = elig_next;
    live_next.cycles_issued[COUNTER_WIDTH-1:0]   = iss_next;
  end

  // Snapshot handshake: snap_valid rises on DONE entry and holds with snap_*
  // stable until a cycle where snap_valid && snap_ready, after which it drops
  // and stays low until a later run completes.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state      <= ST_IDLE;
      idle_cnt   <= '0;
      finished   <= 1'b0;
      running    <= 1'b0;
      snap_valid <= 1'b0;
      snap_q     <= '0;
    end else begin
      if (snap_valid && snap_ready) begin
        snap_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          idle_cnt <= '0;
          if (!busy) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (busy) begin
            state    <= ST_RUN;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_inc;
            // The final drain cycle is still counted, so capture post-update values.
            if (idle_inc == IDLE_W'(IDLE_THRESHOLD - 1)) begin
              state      <= ST_DONE;
              running    <= 1'b0;
              finished   <= 1'b1;
              snap_valid <= 1'b1;
              snap_q     <= live_next;
            end
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  assign snap_instRetired    = snap_q.inst_retired[COUNTER_WIDTH-1:0];
  assign snap_cycles         = snap_q.cycles[COUNTER_WIDTH-1:0];
  assign snap_cyclesDecoded  = snap_q.cycles_decoded[COUNTER_WIDTH-1:0];
  assign snap_cyclesEligible = snap_q.cycles_eligible[COUNTER_WIDTH-1:0];
  assign snap_cyclesIssued   = snap_q.cycles_issued[COUNTER_WIDTH-1:0];

endmodule

// File: tb/tb_backend_perf_counters.sv
// Directed bench for backend_perf_counters: a 64-bit instance for run/drain/
// snapshot behaviour and an 8-bit instance for saturation.
module tb_backend_perf_counters;
  import perf_pkg::*;

  localparam int T = 16;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic       start, clear, busy, snap_ready;
  logic [2:0] retire_count;
  logic       ev_decoded, ev_eligible, ev_issued;

  logic [63:0] inst, cyc, dec, elig, iss;
  logic [63:0] s_inst, s_cyc, s_dec, s_elig, s_iss;
  logic        finished, running, snap_valid;
  logic [1:0]  dstate;

  logic [7:0]  inst8, cyc8, dec8, elig8, iss8;
  logic [7:0]  s_inst8, s_cyc8, s_dec8, s_elig8, s_iss8;
  logic        finished8, running8, snap_valid8;
  logic [1:0]  dstate8;

  backend_perf_counters dut (
    .clock(clock), .reset(reset), .start(start), .clear(clear), .busy(busy),
    .retire_count(retire_count), .ev_decoded(ev_decoded), .ev_eligible(ev_eligible),
    .ev_issued(ev_issued),
    .perf_backend_instRetired(inst), .perf_backend_cycles(cyc),
    .perf_backend_cyclesDecoded(dec), .perf_backend_cyclesEligible(elig),
    .perf_backend_cyclesIssued(iss),
    .finished(finished), .running(running), .snap_valid(snap_valid), .snap_ready(snap_ready),
    .snap_instRetired(s_inst), .snap_cycles(s_cyc), .snap_cyclesDecoded(s_dec),
    .snap_cyclesEligible(s_elig), .snap_cyclesIssued(s_iss), .debug_state(dstate)
  );

  backend_perf_counters #(.COUNTER_WIDTH(8), .RETIRE_WIDTH(3), .IDLE_THRESHOLD(T)) dut8 (
    .clock(clock), .reset(reset), .start(start), .clear(clear), .busy(busy),
    .retire_count(retire_count), .ev_decoded(ev_decoded), .ev_eligible(ev_eligible),
    .ev_issued(ev_issued),
    .perf_backend_instRetired(inst8), .perf_backend_cycles(cyc8),
    .perf_backend_cyclesDecoded(dec8), .perf_backend_cyclesEligible(elig8),
    .perf_backend_cyclesIssued(iss8),
    .finished(finished8), .running(running8), .snap_valid(snap_valid8), .snap_ready(snap_ready),
    .snap_instRetired(s_inst8), .snap_cycles(s_cyc8), .snap_cyclesDecoded(s_dec8),
    .snap_cyclesEligible(s_elig8), .snap_cyclesIssued(s_iss8), .debug_state(dstate8)
  );

  // scoreboard
  int n_vec  = 0;
  int n_miss = 0;
  logic [63:0] exp_q[$];

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; clear = 1'b0; busy = 1'b0; snap_ready = 1'b0;
    retire_count = 3'd0; ev_decoded = 1'b0; ev_eligible = 1'b0; ev_issued = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Steps until finished rises or the budget runs out; returns steps taken.
  task automatic wait_finished(output int n);
    n = 0;
    while (!finished && n < 200) begin
      step();
      n++;
    end
  endtask

  int n, m;

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (3) step();
    check_vec("rst_cycles", cyc, 64'd0);
    check_vec("rst_inst", inst, 64'd0);
    check_vec("rst_finished", {63'd0, finished}, 64'd0);
    check_vec("rst_running", {63'd0, running}, 64'd0);
    check_vec("rst_snap_valid", {63'd0, snap_valid}, 64'd0);
    check_vec("rst_state", {62'd0, dstate}, 64'(ST_IDLE));
    reset = 1'b0;
    step();

    // Basic run: 10 busy cycles retiring 2 with issue, then drain to DONE.
    do_start();
    check_vec("a_running", {63'd0, running}, 64'd1);
    check_vec("a_start_not_counted", cyc, 64'd0);
    busy = 1'b1; retire_count = 3'd2; ev_issued = 1'b1;
    repeat (10) step();
    check_vec("a_inst_mid", inst, 64'd20);
    busy = 1'b0; retire_count = 3'd0; ev_issued = 1'b0;
    wait_finished(n);
    check_vec("a_finish_latency", 64'(10 + n), 64'(10 + T));
    check_vec("a_cycles", cyc, 64'(10 + T));
    check_vec("a_inst", inst, 64'd20);
    check_vec("a_issued", iss, 64'd10);
    check_vec("a_decoded", dec, 64'd0);
    check_vec("a_snap_valid", {63'd0, snap_valid}, 64'd1);
    check_vec("a_running_done", {63'd0, running}, 64'd0);
    check_vec("a_state", {62'd0, dstate}, 64'(ST_DONE));
    exp_q.push_back(64'(10 + T));
    exp_q.push_back(64'd20);
    exp_q.push_back(64'd10);

    // Snapshot held 20 cycles with events and start in DONE ignored.
    busy = 1'b1; ev_decoded = 1'b1; retire_count = 3'd5; start = 1'b1;
    repeat (20) step();
    busy = 1'b0; ev_decoded = 1'b0; retire_count = 3'd0; start = 1'b0;
    check_vec("b_snap_valid_held", {63'd0, snap_valid}, 64'd1);
    check_vec("b_cycles_frozen", cyc, 64'(10 + T));
    check_vec("b_decoded_frozen", dec, 64'd0);
    check_vec("b_state_done", {62'd0, dstate}, 64'(ST_DONE));
    check_vec("b_snap_cycles", s_cyc, exp_q.pop_front());
    check_vec("b_snap_inst", s_inst, exp_q.pop_front());
    check_vec("b_snap_issued", s_iss, exp_q.pop_front());
    snap_ready = 1'b1;
    step();
    snap_ready = 1'b0;
    check_vec("b_snap_valid_drop", {63'd0, snap_valid}, 64'd0);
    snap_ready = 1'b1;
    repeat (5) step();
    snap_ready = 1'b0;
    check_vec("b_snap_no_reassert", {63'd0, snap_valid}, 64'd0);
    check_vec("b_finished_sticky", {63'd0, finished}, 64'd1);

    // clear returns to IDLE with everything zeroed.
    do_clear();
    check_vec("c_state", {62'd0, dstate}, 64'(ST_IDLE));
    check_vec("c_finished", {63'd0, finished}, 64'd0);
    check_vec("c_cycles", cyc, 64'd0);
    check_vec("c_issued", iss, 64'd0);

    // Busy glitch in DRAIN after 5 idle cycles delays DONE by 6.
    do_start();
    busy = 1'b1; ev_decoded = 1'b1;
    repeat (10) step();
    busy = 1'b0; ev_decoded = 1'b0;
    repeat (5) step();
    check_vec("d_state_drain", {62'd0, dstate}, 64'(ST_DRAIN));
    busy = 1'b1;
    step();
    busy = 1'b0;
    check_vec("d_state_back_run", {62'd0, dstate}, 64'(ST_RUN));
    wait_finished(m);
    check_vec("d_finish_latency", 64'(5 + 1 + m), 64'(T + 6));
    check_vec("d_cycles", cyc, 64'(16 + T));
    check_vec("d_decoded", dec, 64'd10);

    // start and clear together in IDLE: clear wins.
    do_clear();
    start = 1'b1; clear = 1'b1;
    step();
    start = 1'b0; clear = 1'b0;
    busy = 1'b1; ev_eligible = 1'b1;
    repeat (3) step();
    busy = 1'b0; ev_eligible = 1'b0;
    check_vec("e_state_idle", {62'd0, dstate}, 64'(ST_IDLE));
    check_vec("e_cycles", cyc, 64'd0);
    check_vec("e_eligible", elig, 64'd0);

    // Saturation on the 8-bit instance.
    do_start();
    busy = 1'b1; retire_count = 3'd7;
    repeat (40) step();
    check_vec("f_inst8_sat", {56'd0, inst8}, 64'd255);
    check_vec("f_cyc8", {56'd0, cyc8}, 64'd40);
    check_vec("f_inst64", inst, 64'd280);
    repeat (10) step();
    check_vec("f_inst8_hold", {56'd0, inst8}, 64'd255);
    check_vec("f_cyc8_cont", {56'd0, cyc8}, 64'd50);

    // Reset mid-run discards everything and never reaches DONE.
    reset = 1'b1;
    step();
    reset = 1'b0;
    busy = 1'b0; retire_count = 3'd0;
    check_vec("g_inst", inst, 64'd0);
    check_vec("g_cycles", cyc, 64'd0);
    check_vec("g_running", {63'd0, running}, 64'd0);
    check_vec("g_snap_valid", {63'd0, snap_valid}, 64'd0);
    check_vec("g_snap_inst", s_inst, 64'd0);
    repeat (T + 5) step();
    check_vec("g_no_done", {63'd0, finished}, 64'd0);
    check_vec("g_state_idle", {62'd0, dstate}, 64'(ST_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
